mem_ctrl: RTL and testbench

- Single owner of the byte-wide RAM/IO port.
- Arbitrates between the instruction fetch unit (4-byte reads) and the load/store buffer (1/2/4-byte reads and writes).
- Serialises each access into per-byte RAM cycles, reassembles read data little-endian, and returns one-cycle completion pulses.
- Handles pipeline flush (clear) and IO back-pressure (io_buffer_full).

---
 rtl/mem_ctrl_pkg.sv | 32 +++
 rtl/mem_req_slot.sv | 52 +++++
 rtl/mem_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the byte-wide memory controller.
//   - mc_state_e : controller FSM states (idle, multi-byte read, multi-byte write)
//   - grant_e    : requester identity used for round-robin arbitration
//   - len_bytes  : normalises an LSB length code to an actual byte count
package mem_ctrl_pkg;

  localparam int unsigned LenW          = 3;
  localparam logic        AccRead       = 1'b0;
  localparam logic        AccWrite      = 1'b1;
  localparam logic [31:0] IoBaseDefault = 32'h0003_0000;

  typedef enum logic [1:0] {
    McIdle  = 2'd0,
    McRead  = 2'd1,
    McWrite = 2'd2
  } mc_state_e;

  typedef enum logic {
    GrantIf  = 1'b0,
    GrantLsb = 1'b1
  } grant_e;

  // Only 1 and 2 are honoured as-is; every other code means a full word.
  function automatic logic [LenW-1:0] len_bytes(input logic [LenW-1:0] len);
    case (len)
      3'd1:    len_bytes = 3'd1;
      3'd2:    len_bytes = 3'd2;
      default: len_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_req_slot.sv
// mem_req_slot: one-deep pending-request register (valid flag + payload).
//   clk, rst       : clock, synchronous active-high reset
//   en_i           : global enable; low holds the slot
//   flush_i        : drop the pending request (highest priority)
//   load_i         : capture load_data_i and mark the slot valid
//   consume_i      : the request has been granted; empty the slot
//   valid_o/data_o : slot contents
// A load on the same edge as a consume keeps the new request.
module mem_req_slot #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic             consume_i,
  input  logic [Width-1:0] load_data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
    end else if (consume_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: sole owner of the byte-wide RAM/IO port.
//   clk, rst, rdy, clear     : clock, sync reset, global enable, pipeline flush
//   if_req/if_addr           : 4-byte fetch request; if_valid/if_data completion
//   lsb_req/lsb_is_write/lsb_addr/lsb_len/lsb_wdata : load/store request
//   lsb_valid/lsb_rdata      : load data or store ack (zero-extended)
//   mem_din/mem_dout/mem_a/mem_wr : byte RAM port, read data one cycle after address
//   io_buffer_full           : back-pressure on writes to addresses >= IO_BASE
// Each access is split into per-byte RAM cycles; read bytes are reassembled little-endian.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IoBaseDefault)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [31:0]       if_data,
  input  logic              lsb_req,
  input  logic              lsb_is_write,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [LenW-1:0]   lsb_len,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_valid,
  output logic [31:0]       lsb_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  localparam int unsigned LsbPayloadW = 1 + LenW + 32 + ADDR_W;

  // Pending slots
  logic                   if_pend, lsb_pend;
  logic [ADDR_W-1:0]      if_pend_addr;
  logic [LsbPayloadW-1:0] lsb_pend_data;
  logic                   grant_if, grant_lsb;

  mem_req_slot #(.Width(ADDR_W)) u_if_slot (
    .clk         (clk),
    .rst         (rst),
    .en_i        (rdy),
    .flush_i     (clear),
    .load_i      (if_req),
    .consume_i   (grant_if),
    .load_data_i (if_addr),
    .valid_o     (if_pend),
    .data_o      (if_pend_addr)
  );

  mem_req_slot #(.Width(LsbPayloadW)) u_lsb_slot (
    .clk         (clk),
    .rst         (rst),
    .en_i        (rdy),
    .flush_i     (clear),
    .load_i      (lsb_req),
    .consume_i   (grant_lsb),
    .load_data_i ({lsb_is_write, lsb_len, lsb_wdata, lsb_addr}),
    .valid_o     (lsb_pend),
    .data_o      (lsb_pend_data)
  );

  // Controller state
  mc_state_e         state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  grant_e            cur_src_q, cur_src_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LenW-1:0]   cur_len_q, cur_len_d;
  logic [31:0]       cur_wdata_q, cur_wdata_d;
  // READ: index of the last edge since grant. WRITE: bytes already written.
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       acc_q, acc_d;
  logic              suppress_q, suppress_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              if_valid_q, if_valid_d;
  logic [31:0]       if_data_q, if_data_d;
  logic              lsb_valid_q, lsb_valid_d;
  logic [31:0]       lsb_rdata_q, lsb_rdata_d;

  // Grant decode
  logic              g_write;
  logic [LenW-1:0]   g_len;
  logic [31:0]       g_wdata;
  logic [ADDR_W-1:0] g_addr;
  logic [1:0]        rd_idx;
  logic [ADDR_W-1:0] wr_addr;

  always_comb begin
    grant_if  = 1'b0;
    grant_lsb = 1'b0;
    // A flush drops pending requests, so nothing is granted on that edge.
    if (state_q == McIdle && !clear) begin
      if (if_pend && lsb_pend) begin
        if (last_grant_q == GrantIf) grant_lsb = 1'b1;
        else                         grant_if  = 1'b1;
      end else if (if_pend) begin
        grant_if = 1'b1;
      end else if (lsb_pend) begin
        grant_lsb = 1'b1;
      end
    end
  end

  always_comb begin
    if (grant_if) begin
      g_write = AccRead;
      g_len   = 3'd4;
      g_wdata = '0;
      g_addr  = if_pend_addr;
    end else begin
      g_write = lsb_pend_data[LsbPayloadW-1];
      g_len   = len_bytes(lsb_pend_data[LsbPayloadW-2 -: LenW]);
      g_wdata = lsb_pend_data[ADDR_W +: 32];
      g_addr  = lsb_pend_data[ADDR_W-1:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_src_d    = cur_src_q;
    cur_addr_d   = cur_addr_q;
    cur_len_d    = cur_len_q;
    cur_wdata_d  = cur_wdata_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    suppress_d   = suppress_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;
    if_valid_d   = 1'b0;
    if_data_d    = if_data_q;
    lsb_valid_d  = 1'b0;
    lsb_rdata_d  = lsb_rdata_q;
    rd_idx       = 2'(cnt_q - 3'd1);
    wr_addr      = cur_addr_q + ADDR_W'(cnt_q);

    unique case (state_q)
      McIdle: begin
        mem_wr_d = 1'b0;
        if (grant_if || grant_lsb) begin
          last_grant_d = grant_if ? GrantIf : GrantLsb;
          cur_src_d    = grant_if ? GrantIf : GrantLsb;
          cur_addr_d   = g_addr;
          cur_len_d    = g_len;
          cur_wdata_d  = g_wdata;
          acc_d        = '0;
          suppress_d   = 1'b0;
          if (g_write == AccWrite) begin
            state_d = McWrite;
            if (g_addr >= IO_BASE && io_buffer_full) begin
              cnt_d = 3'd0;
            end else begin
              mem_a_d    = g_addr;
              mem_dout_d = g_wdata[7:0];
              mem_wr_d   = 1'b1;
              cnt_d      = 3'd1;
            end
          end else begin
            state_d = McRead;
            mem_a_d = g_addr;
            cnt_d   = 3'd0;
          end
        end
      end

      McRead: begin
        if (clear) begin
          state_d = McIdle;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_d < cur_len_q) mem_a_d = cur_addr_q + ADDR_W'(cnt_d);
          // RAM returns byte k one edge after its address, captured one edge later.
          if (cnt_q != 3'd0) acc_d[{rd_idx, 3'b000} +: 8] = mem_din;
          if (cnt_q == cur_len_q) begin
            state_d = McIdle;
            if (cur_src_q == GrantIf) begin
              if_valid_d = 1'b1;
              if_data_d  = acc_d;
            end else begin
              lsb_valid_d = 1'b1;
              lsb_rdata_d = acc_d;
            end
          end
        end
      end

      McWrite: begin
        // A committed store always drains; a flush only hides its ack.
        if (clear) suppress_d = 1'b1;
        if (cnt_q == cur_len_q) begin
          mem_wr_d    = 1'b0;
          state_d     = McIdle;
          lsb_valid_d = !(suppress_q || clear);
        end else if (wr_addr >= IO_BASE && io_buffer_full) begin
          mem_wr_d = 1'b0;
        end else begin
          mem_a_d    = wr_addr;
          mem_dout_d = cur_wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          mem_wr_d   = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end
      end

      default: state_d = McIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= McIdle;
      last_grant_q <= GrantIf;
      cur_src_q    <= GrantIf;
      cur_addr_q   <= '0;
      cur_len_q    <= '0;
      cur_wdata_q  <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      suppress_q   <= 1'b0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      if_valid_q   <= 1'b0;
      if_data_q    <= '0;
      lsb_valid_q  <= 1'b0;
      lsb_rdata_q  <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_src_q    <= cur_src_d;
      cur_addr_q   <= cur_addr_d;
      cur_len_q    <= cur_len_d;
      cur_wdata_q  <= cur_wdata_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      suppress_q   <= suppress_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      if_valid_q   <= if_valid_d;
      if_data_q    <= if_data_d;
      lsb_valid_q  <= lsb_valid_d;
      lsb_rdata_q  <= lsb_rdata_d;
    end
  end

  // Pulses are held with the rest of the state while frozen, so mask them.
  assign if_valid  = if_valid_q & rdy;
  assign lsb_valid = lsb_valid_q & rdy;
  assign if_data   = if_data_q;
  assign lsb_rdata = lsb_rdata_q;
  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl. Expected completions and RAM writes are queued
// when requests are driven and checked when the controller produces them.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int SrcIf  = 1;
  localparam int SrcLsb = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct packed {
    logic        chk;
    logic [31:0] data;
  } lsb_t;

  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic        if_req, if_valid;
  logic [31:0] if_addr, if_data;
  logic        lsb_req, lsb_is_write, lsb_valid;
  logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
  logic [2:0]  lsb_len;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] if_q[$];
  lsb_t        lsb_q[$];
  wr_t         wr_q[$];
  int          order_q[$];

  mem_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .clear          (clear),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_valid       (if_valid),
    .if_data        (if_data),
    .lsb_req        (lsb_req),
    .lsb_is_write   (lsb_is_write),
    .lsb_addr       (lsb_addr),
    .lsb_len        (lsb_len),
    .lsb_wdata      (lsb_wdata),
    .lsb_valid      (lsb_valid),
    .lsb_rdata      (lsb_rdata),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h100:  ram_byte = 8'h13;
      32'h101:  ram_byte = 8'h05;
      32'h200:  ram_byte = 8'h11;
      32'h201:  ram_byte = 8'h22;
      32'h202:  ram_byte = 8'h33;
      32'h203:  ram_byte = 8'h44;
      32'h3004: ram_byte = 8'h80;
      32'h3005: ram_byte = 8'h55;
      default:  ram_byte = 8'h00;
    endcase
  endfunction

  // Synchronous-read RAM: byte appears one cycle after its address.
  always @(posedge clk) mem_din <= ram_byte(mem_a);

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (if_req) check_eq("if_proto", 32'(dut.if_pend & ~dut.grant_if), 32'd0);
      if (lsb_req) check_eq("lsb_proto", 32'(dut.lsb_pend & ~dut.grant_lsb), 32'd0);
      if (if_valid) begin
        if (if_q.size() == 0 || order_q.size() == 0) begin
          check_eq("if_spurious", 32'd1, 32'd0);
        end else begin
          check_eq("order_if", 32'(SrcIf), 32'(order_q.pop_front()));
          check_eq("if_data", if_data, if_q.pop_front());
        end
      end
      if (lsb_valid) begin
        if (lsb_q.size() == 0 || order_q.size() == 0) begin
          check_eq("lsb_spurious", 32'd1, 32'd0);
        end else begin
          lsb_t e;
          e = lsb_q.pop_front();
          check_eq("order_lsb", 32'(SrcLsb), 32'(order_q.pop_front()));
          if (e.chk) check_eq("lsb_rdata", lsb_rdata, e.data);
        end
      end
      if (mem_wr) begin
        if (wr_q.size() == 0) begin
          check_eq("wr_spurious", 32'd1, 32'd0);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          check_eq("wr_addr", mem_a, w.addr);
          check_eq("wr_byte", 32'(mem_dout), 32'(w.data));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_if(input logic [31:0] d);
    if_q.push_back(d);
    order_q.push_back(SrcIf);
  endtask

  task automatic exp_lsb(input logic chk, input logic [31:0] d);
    lsb_t e;
    e.chk = chk;
    e.data = d;
    lsb_q.push_back(e);
    order_q.push_back(SrcLsb);
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wr_q.push_back(w);
  endtask

  // Drive a one-cycle LSB pulse; returns just after the capture edge.
  task automatic issue_lsb(input logic wr, input logic [31:0] a, input logic [2:0] len,
                           input logic [31:0] wd);
    lsb_req = 1'b1; lsb_is_write = wr; lsb_addr = a; lsb_len = len; lsb_wdata = wd;
    step(1);
    lsb_req = 1'b0;
  endtask

  task automatic issue_if(input logic [31:0] a);
    if_req = 1'b1; if_addr = a;
    step(1);
    if_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; if_req = 1'b0; if_addr = '0;
    lsb_req = 1'b0; lsb_is_write = 1'b0; lsb_addr = '0; lsb_len = 3'd1; lsb_wdata = '0;
    io_buffer_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check_eq("rst_if_valid", 32'(if_valid), 32'd0);
    check_eq("rst_lsb_valid", 32'(lsb_valid), 32'd0);
    check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
    check_eq("rst_mem_a", mem_a, 32'd0);
    check_eq("rst_mem_dout", 32'(mem_dout), 32'd0);
    check_eq("rst_if_data", if_data, 32'd0);
    check_eq("rst_lsb_rdata", lsb_rdata, 32'd0);

    // Fetch 0x100: bytes 13 05 00 00
    exp_if(32'h0000_0513);
    issue_if(32'h100);
    for (int k = 0; k < 4; k++) begin
      step(1);
      check_eq("fetch_mem_a", mem_a, 32'h100 + 32'(k));
      check_eq("fetch_mem_wr", 32'(mem_wr), 32'd0);
    end
    step(1);
    check_eq("fetch_e4_valid", 32'(if_valid), 32'd0);
    step(1);
    check_eq("fetch_e5_valid", 32'(if_valid), 32'd1);
    step(2);

    // Both request together, last grant was IF: LSB (LH 0x200) goes first
    exp_lsb(1'b1, 32'h0000_2211);
    exp_if(32'h0000_0513);
    if_req = 1'b1; if_addr = 32'h100;
    issue_lsb(1'b0, 32'h200, 3'd2, 32'h0);
    if_req = 1'b0;
    step(12);

    // SW 0x2000
    exp_wr(32'h2000, 8'hEF); exp_wr(32'h2001, 8'hBE);
    exp_wr(32'h2002, 8'hAD); exp_wr(32'h2003, 8'hDE);
    exp_lsb(1'b0, 32'h0);
    issue_lsb(1'b1, 32'h2000, 3'd4, 32'hDEAD_BEEF);
    for (int k = 0; k < 4; k++) begin
      step(1);
      check_eq("sw_mem_wr", 32'(mem_wr), 32'd1);
      check_eq("sw_valid_early", 32'(lsb_valid), 32'd0);
    end
    step(1);
    check_eq("sw_e4_valid", 32'(lsb_valid), 32'd1);
    check_eq("sw_e4_mem_wr", 32'(mem_wr), 32'd0);
    step(2);

    // Both again, last grant was LSB: IF first. lsb_len 3 acts as a word.
    exp_if(32'h0000_0513);
    exp_lsb(1'b1, 32'h4433_2211);
    if_req = 1'b1; if_addr = 32'h100;
    issue_lsb(1'b0, 32'h200, 3'd3, 32'h0);
    if_req = 1'b0;
    step(14);

    // LB 0x3004
    exp_lsb(1'b1, 32'h0000_0080);
    issue_lsb(1'b0, 32'h3004, 3'd1, 32'h0);
    step(1);
    check_eq("lb_mem_a", mem_a, 32'h3004);
    step(1);
    check_eq("lb_e1_valid", 32'(lsb_valid), 32'd0);
    check_eq("lb_e1_mem_a", mem_a, 32'h3004);
    step(1);
    check_eq("lb_e2_valid", 32'(lsb_valid), 32'd1);
    step(2);

    // SB to IO space with back-pressure for three edges
    exp_wr(32'h0003_0000, 8'hA5);
    exp_lsb(1'b0, 32'h0);
    issue_lsb(1'b1, 32'h0003_0000, 3'd1, 32'h0000_00A5);
    io_buffer_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1);
      check_eq("io_stall_wr", 32'(mem_wr), 32'd0);
    end
    io_buffer_full = 1'b0;
    step(1);
    check_eq("io_write_wr", 32'(mem_wr), 32'd1);
    check_eq("io_write_valid", 32'(lsb_valid), 32'd0);
    step(1);
    check_eq("io_done_valid", 32'(lsb_valid), 32'd1);
    check_eq("io_done_wr", 32'(mem_wr), 32'd0);
    step(2);

    // Clear mid-LW after two bytes captured; IF queued behind it is dropped
    issue_lsb(1'b0, 32'h200, 3'd4, 32'h0);
    step(2);
    issue_if(32'h100);
    step(1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check_eq("clr_rd_idle", 32'(dut.state_q), 32'(McIdle));
    step(8);

    // Clear mid-SH: both bytes still written, ack suppressed
    exp_wr(32'h2100, 8'h34); exp_wr(32'h2101, 8'h12);
    issue_lsb(1'b1, 32'h2100, 3'd2, 32'hBEEF_1234);
    step(1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(6);
    check_eq("clr_wr_idle", 32'(dut.state_q), 32'(McIdle));

    check_eq("if_q_left", 32'(if_q.size()), 32'd0);
    check_eq("lsb_q_left", 32'(lsb_q.size()), 32'd0);
    check_eq("wr_q_left", 32'(wr_q.size()), 32'd0);
    check_eq("order_q_left", 32'(order_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
